// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Write-side front end for the 32x32 register file. Merges the in-order ALU
// writeback stream and a long-latency unit (load/mul/div) into the single
// register-file write port A3/WD3/WE3. Long-latency results wait in a small
// FIFO. ALU writes always win. A scoreboard query reports whether a register
// still has a queued write pending.
//
// Ports:
//   CLK               clock, all state updates on posedge
//   RST               asynchronous, active-low reset
//   alu_we/rd/wd      ALU result; always accepted, never stalled
//   lu_valid/rd/wd    long-unit result offered
//   lu_ready          FIFO can accept (!full), 0 while in reset
//   q_rd, q_busy      scoreboard query: a live queued write targets q_rd
//   pend_cnt          occupied FIFO entries (live and killed)
//   A3/WD3/WE3        registered register-file write port
//
// Handshake (lu_valid/lu_ready): a result transfers on a posedge where both
// are high. lu_ready depends only on FIFO occupancy and reset, never on
// lu_valid. The producer holds lu_rd/lu_wd stable while lu_valid is high and
// lu_ready is low. A transfer with lu_rd==0 completes but stores nothing.
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             alu_we,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_wd,
    input  logic             lu_valid,
    input  logic [4:0]       lu_rd,
    input  logic [31:0]      lu_wd,
    output logic             lu_ready,
    input  logic [4:0]       q_rd,
    output logic             q_busy,
    output logic [PTR_W:0]   pend_cnt,
    output logic [4:0]       A3,
    output logic [31:0]      WD3,
    output logic             WE3
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] ONE_PTR  = {{(PTR_W - 1){1'b0}}, 1'b1};

    logic [DEPTH-1:0] live_q;
    logic [4:0]       rd_mem [DEPTH];
    logic [31:0]      wd_mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   cnt_q;
    logic [PTR_W:0]   cnt_nxt;

    logic alu_wr;
    logic push;
    logic store;
    logic pop;

    // An ALU write to x0 is not a write, so it does not block a pop.
    assign alu_wr   = alu_we && (alu_rd != 5'd0);
    assign lu_ready = RST && (cnt_q != FULL_CNT);
    assign push     = lu_valid && lu_ready;
    // x0 results complete the handshake but are never stored.
    assign store    = push && (lu_rd != 5'd0);
    assign pop      = !alu_wr && (cnt_q != '0);
    assign pend_cnt = cnt_q;

    always_comb begin
        cnt_nxt = cnt_q;
        if (store && !pop) begin
            cnt_nxt = cnt_q + ONE_CNT;
        end else if (!store && pop) begin
            cnt_nxt = cnt_q - ONE_CNT;
        end
    end

    // Live bits are cleared on pop, so a set live bit always belongs to an
    // entry still stored in the FIFO.
    always_comb begin
        q_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_mem[i] == q_rd) && (q_rd != 5'd0)) begin
                q_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            A3     <= 5'd0;
            WD3    <= 32'd0;
            WE3    <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            live_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem[i] <= 5'd0;
                wd_mem[i] <= 32'd0;
            end
        end else begin
            // Output stage: ALU first, then FIFO head, else hold address/data.
            if (alu_wr) begin
                A3  <= alu_rd;
                WD3 <= alu_wd;
                WE3 <= 1'b1;
            end else if (pop) begin
                A3  <= rd_mem[head_q];
                WD3 <= wd_mem[head_q];
                WE3 <= live_q[head_q];
            end else begin
                WE3 <= 1'b0;
            end

            // WAW kill: older queued writes to the ALU's rd must not land
            // after the ALU value. Only entries already stored are affected;
            // a same-cycle push is set live below and wins.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_wr && (rd_mem[i] == alu_rd)) begin
                    live_q[i] <= 1'b0;
                end
            end

            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + ONE_PTR;
            end

            if (store) begin
                rd_mem[tail_q] <= lu_rd;
                wd_mem[tail_q] <= lu_wd;
                live_q[tail_q] <= 1'b1;
                tail_q         <= tail_q + ONE_PTR;
            end

            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic        CLK;
    logic        RST;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic [4:0]  q_rd;
    logic        q_busy;
    logic [2:0]  pend_cnt;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;

    int n_cmp;
    int n_err;

    rf_write_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .alu_we   (alu_we),
        .alu_rd   (alu_rd),
        .alu_wd   (alu_wd),
        .lu_valid (lu_valid),
        .lu_rd    (lu_rd),
        .lu_wd    (lu_wd),
        .lu_ready (lu_ready),
        .q_rd     (q_rd),
        .q_busy   (q_busy),
        .pend_cnt (pend_cnt),
        .A3       (A3),
        .WD3      (WD3),
        .WE3      (WE3)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        alu_we   = 1'b0;
        alu_rd   = 5'd0;
        alu_wd   = 32'd0;
        lu_valid = 1'b0;
        lu_rd    = 5'd0;
        lu_wd    = 32'd0;
        q_rd     = 5'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b0;
        idle_inputs();
        step();
        step();
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL reset_we3 actual=%b required=0", WE3); end
        n_cmp++; if (A3 !== 5'd0) begin n_err++; $display("FAIL reset_a3 actual=%0d required=0", A3); end
        n_cmp++; if (WD3 !== 32'd0) begin n_err++; $display("FAIL reset_wd3 actual=%h required=0", WD3); end
        n_cmp++; if (pend_cnt !== 3'd0) begin n_err++; $display("FAIL reset_pend actual=%0d required=0", pend_cnt); end
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low actual=%b required=0", lu_ready); end
        RST = 1'b1;
        #1;
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_release actual=%b required=1", lu_ready); end
        step();
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL idle_we3 actual=%b required=0", WE3); end
    endtask

    task automatic test_alu_only();
        alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
        step();
        n_cmp++; if (WE3 !== 1'b1) begin n_err++; $display("FAIL alu_we3 actual=%b required=1", WE3); end
        n_cmp++; if (A3 !== 5'd5) begin n_err++; $display("FAIL alu_a3 actual=%0d required=5", A3); end
        n_cmp++; if (WD3 !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_wd3 actual=%h required=deadbeef", WD3); end
        idle_inputs();
        step();
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL alu_after_we3 actual=%b required=0", WE3); end
        n_cmp++; if (A3 !== 5'd5) begin n_err++; $display("FAIL alu_hold_a3 actual=%0d required=5", A3); end
    endtask

    task automatic test_drain();
        alu_we = 1'b1; alu_rd = 5'd7; alu_wd = 32'h70;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_wd = 32'h11;
        step();
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h70) begin n_err++; $display("FAIL drain_alu0 actual=%b/%0d/%h required=1/7/70", WE3, A3, WD3); end
        n_cmp++; if (pend_cnt !== 3'd1) begin n_err++; $display("FAIL drain_pend1 actual=%0d required=1", pend_cnt); end
        alu_wd = 32'h71; lu_rd = 5'd4; lu_wd = 32'h22;
        step();
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h71) begin n_err++; $display("FAIL drain_alu1 actual=%b/%0d/%h required=1/7/71", WE3, A3, WD3); end
        n_cmp++; if (pend_cnt !== 3'd2) begin n_err++; $display("FAIL drain_pend2 actual=%0d required=2", pend_cnt); end
        idle_inputs();
        step();
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'h11) begin n_err++; $display("FAIL drain_pop3 actual=%b/%0d/%h required=1/3/11", WE3, A3, WD3); end
        n_cmp++; if (pend_cnt !== 3'd1) begin n_err++; $display("FAIL drain_pend_a actual=%0d required=1", pend_cnt); end
        step();
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd4 || WD3 !== 32'h22) begin n_err++; $display("FAIL drain_pop4 actual=%b/%0d/%h required=1/4/22", WE3, A3, WD3); end
        n_cmp++; if (pend_cnt !== 3'd0) begin n_err++; $display("FAIL drain_pend_b actual=%0d required=0", pend_cnt); end
        step();
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL drain_empty_we3 actual=%b required=0", WE3); end
    endtask

    task automatic test_full();
        alu_we = 1'b1; alu_rd = 5'd1; alu_wd = 32'h1;
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_wd = 32'h100 + 32'(i);
            #1;
            n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_fill%0d actual=%b required=1", i, lu_ready); end
            step();
        end
        n_cmp++; if (pend_cnt !== 3'd4) begin n_err++; $display("FAIL full_pend4 actual=%0d required=4", pend_cnt); end
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low actual=%b required=0", lu_ready); end
        lu_rd = 5'd14; lu_wd = 32'h104;
        step();
        n_cmp++; if (pend_cnt !== 3'd4) begin n_err++; $display("FAIL full_no_fifth actual=%0d required=4", pend_cnt); end
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd1) begin n_err++; $display("FAIL full_alu_hold actual=%b/%0d required=1/1", WE3, A3); end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'(10 + i) || WD3 !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL full_pop%0d actual=%b/%0d/%h required=1/%0d/%h", i, WE3, A3, WD3, 10 + i, 32'h100 + 32'(i)); end
            n_cmp++; if (pend_cnt !== 3'(3 - i)) begin n_err++; $display("FAIL full_pend_pop%0d actual=%0d required=%0d", i, pend_cnt, 3 - i); end
            n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_pop%0d actual=%b required=1", i, lu_ready); end
        end
    endtask

    task automatic test_waw_kill();
        q_rd = 5'd9;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_wd = 32'hAA;
        step();
        n_cmp++; if (q_busy !== 1'b1) begin n_err++; $display("FAIL waw_busy_before actual=%b required=1", q_busy); end
        n_cmp++; if (pend_cnt !== 3'd1) begin n_err++; $display("FAIL waw_pend_q actual=%0d required=1", pend_cnt); end
        lu_valid = 1'b0;
        alu_we = 1'b1; alu_rd = 5'd9; alu_wd = 32'hBB;
        step();
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'hBB) begin n_err++; $display("FAIL waw_alu actual=%b/%0d/%h required=1/9/bb", WE3, A3, WD3); end
        n_cmp++; if (q_busy !== 1'b0) begin n_err++; $display("FAIL waw_busy_after actual=%b required=0", q_busy); end
        n_cmp++; if (pend_cnt !== 3'd1) begin n_err++; $display("FAIL waw_pend_killed actual=%0d required=1", pend_cnt); end
        alu_we = 1'b0; alu_rd = 5'd0;
        step();
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL waw_bubble_we3 actual=%b required=0", WE3); end
        n_cmp++; if (pend_cnt !== 3'd0) begin n_err++; $display("FAIL waw_bubble_pend actual=%0d required=0", pend_cnt); end

        // Same-cycle push to the ALU's rd is newer and survives.
        q_rd = 5'd6;
        alu_we = 1'b1; alu_rd = 5'd6; alu_wd = 32'h61;
        lu_valid = 1'b1; lu_rd = 5'd6; lu_wd = 32'h62;
        step();
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd6 || WD3 !== 32'h61) begin n_err++; $display("FAIL same_alu actual=%b/%0d/%h required=1/6/61", WE3, A3, WD3); end
        n_cmp++; if (q_busy !== 1'b1) begin n_err++; $display("FAIL same_busy actual=%b required=1", q_busy); end
        idle_inputs();
        step();
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd6 || WD3 !== 32'h62) begin n_err++; $display("FAIL same_pop actual=%b/%0d/%h required=1/6/62", WE3, A3, WD3); end
    endtask

    task automatic test_x0_wrap();
        q_rd = 5'd0;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_wd = 32'hBAD0;
        #1;
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready actual=%b required=1", lu_ready); end
        step();
        n_cmp++; if (pend_cnt !== 3'd0) begin n_err++; $display("FAIL x0_pend actual=%0d required=0", pend_cnt); end
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL x0_we3 actual=%b required=0", WE3); end
        for (int i = 0; i < 10; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(16 + i); lu_wd = 32'h200 + 32'(i);
            // ALU write to x0 on odd cycles must not block the pop.
            alu_we = (i % 2 == 1); alu_rd = 5'd0; alu_wd = 32'hBAD1;
            step();
            if (i == 0) begin
                n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL wrap_first_we3 actual=%b required=0", WE3); end
            end else begin
                n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'(15 + i) || WD3 !== 32'h200 + 32'(i - 1)) begin n_err++; $display("FAIL wrap_pop%0d actual=%b/%0d/%h required=1/%0d/%h", i, WE3, A3, WD3, 15 + i, 32'h200 + 32'(i - 1)); end
            end
            n_cmp++; if (pend_cnt !== 3'd1) begin n_err++; $display("FAIL wrap_pend%0d actual=%0d required=1", i, pend_cnt); end
        end
        idle_inputs();
        step();
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd25 || WD3 !== 32'h209) begin n_err++; $display("FAIL wrap_last actual=%b/%0d/%h required=1/25/209", WE3, A3, WD3); end
        n_cmp++; if (pend_cnt !== 3'd0) begin n_err++; $display("FAIL wrap_end_pend actual=%0d required=0", pend_cnt); end
    endtask

    task automatic test_reset_mid();
        alu_we = 1'b1; alu_rd = 5'd2; alu_wd = 32'h2;
        lu_valid = 1'b1; lu_rd = 5'd20; lu_wd = 32'h300;
        step();
        lu_rd = 5'd21; lu_wd = 32'h301;
        step();
        n_cmp++; if (pend_cnt !== 3'd2) begin n_err++; $display("FAIL rmid_pend_pre actual=%0d required=2", pend_cnt); end
        idle_inputs();
        q_rd = 5'd20;
        RST = 1'b0;
        #1;
        n_cmp++; if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0) begin n_err++; $display("FAIL rmid_out actual=%b/%0d/%h required=0/0/0", WE3, A3, WD3); end
        n_cmp++; if (pend_cnt !== 3'd0) begin n_err++; $display("FAIL rmid_pend actual=%0d required=0", pend_cnt); end
        n_cmp++; if (q_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy actual=%b required=0", q_busy); end
        step();
        RST = 1'b1;
        step();
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL rmid_no_drain actual=%b required=0", WE3); end
        step();
        n_cmp++; if (WE3 !== 1'b0 || pend_cnt !== 3'd0) begin n_err++; $display("FAIL rmid_idle actual=%b/%0d required=0/0", WE3, pend_cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_alu_only();
        test_drain();
        test_full();
        test_waw_kill();
        test_x0_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
